// File: rtl/imm_pkg.sv
// imm_pkg: RV32I immediate format codes, opcodes and decode-queue entry type.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_NONE  = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int IMM_MAX = 64;

    // imm is held at the widest legal XLEN so one entry type serves both widths
    typedef struct packed {
        logic [31:0]        instr;
        logic [IMM_MAX-1:0] imm;
        imm_fmt_e           fmt;
        logic               illegal;
    } entry_t;

endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational opcode-driven immediate decode for RV32I.
module imm_extract import imm_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o
);

    logic [6:0] op;
    logic       shift;
    logic [5:0] shamt;

    assign op    = instr_i[6:0];
    assign shift = (op == OP_IMM) && (instr_i[13:12] == 2'b01);
    assign shamt = (XLEN == 64) ? instr_i[25:20] : {1'b0, instr_i[24:20]};

    always_comb begin
        imm_o     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: begin
                fmt_o = shift ? FMT_SHAMT : FMT_I;
                imm_o = shift ? XLEN'(shamt) : XLEN'($signed(instr_i[31:20]));
            end
            OP_STORE: begin
                fmt_o = FMT_S;
                imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            end
            OP_BRANCH: begin
                fmt_o = FMT_B;
                imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                fmt_o = FMT_U;
                imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
            end
            OP_JAL: begin
                fmt_o = FMT_J;
                imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
            end
            OP_REG:  fmt_o = FMT_R;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_decode_queue.sv
// imm_decode_queue: decode-stage FIFO storing instructions with pre-decoded immediates.
module imm_decode_queue import imm_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [XLEN-1:0]            out_imm,
    output imm_fmt_e                   out_fmt,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    entry_t        mem_q [DEPTH];
    entry_t        wr, head;
    logic [XLEN-1:0] ext_imm;
    imm_fmt_e      ext_fmt;
    logic          ext_ill;
    logic          push, pop;

    imm_extract #(.XLEN(XLEN)) u_ext (
        .instr_i   (in_instr),
        .imm_o     (ext_imm),
        .fmt_o     (ext_fmt),
        .illegal_o (ext_ill)
    );

    assign in_ready  = cnt_q < (AW+1)'(DEPTH);
    assign out_valid = cnt_q != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt_q;
    assign head      = mem_q[rp_q];

    always_comb begin
        wr    = '{instr: in_instr, imm: IMM_MAX'($signed(ext_imm)), fmt: ext_fmt, illegal: ext_ill};
        wp_d  = flush ? '0 : wp_q + AW'(push);
        rp_d  = flush ? '0 : rp_q + AW'(pop);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Data outputs are gated by occupancy so an empty queue presents zeros
    assign out_instr   = out_valid ? head.instr : '0;
    assign out_imm     = out_valid ? head.imm[XLEN-1:0] : '0;
    assign out_fmt     = out_valid ? head.fmt : FMT_R;
    assign out_illegal = out_valid && head.illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wp_q] <= wr;
    end

endmodule
